mb16_booth_enc: RTL and testbench
=================================

Name: mb16_booth_enc

Overview:
- Radix-8 Booth recoding stage, directly upstream of the registered radix-8 multiplier stage (mb16_td).
- Takes the multiplier operand x and the multiplicand y.
- Produces per-group one-hot digit-select vectors s/d/t/q (|digit| = 1/2/3/4), a negate vector n, the passed-through multiplicand my, and the hard multiple tmy = 3*y.
- 2-stage pipeline with valid/ready handshake. The 3y adder is split across the two stages to meet timing.

Parameters:
- WIDTH, 16, operand width in bits.
- GROUP_CNT, (WIDTH>>2)+2, number of Booth groups (6 for WIDTH=16). Derived; not to be overridden.
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- in_valid  input  1  x/y valid.
- in_ready  output  1  stage can accept x/y this cycle.
- x  input  WIDTH  multiplier operand (recoded).
- y  input  WIDTH  multiplicand.
- out_valid  output  1  s..tmy valid.
- out_ready  input  1  downstream accepts this cycle.
- s, d, t, q, n  output  GROUP_CNT each  digit magnitude one-hots and negate flag, bit i = group i.
- my  output  WIDTH  registered y.
- tmy  output  WIDTH+2  3*y, sign-extended when SIGNED = 1, zero-extended otherwise.

Behaviour:
- Reset: one clock (CLK); reset RST is asynchronous and active-low.
  - While RST = 0, all pipeline valid bits clear. out_valid = 0 and every data output = 0.
  - in_ready = 1 once RST is released.
- Reset asserted mid-operation discards all in-flight data; no partial result is ever presented.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - in_ready = !v1 | !v2 | out_ready, where v1/v2 are the stage valid bits. This gives full throughput with no bubbles when out_ready stays high.
  - When out_ready = 0, the outputs hold stable (s..tmy and out_valid unchanged) until accepted.
  - A stalled stage 2 back-pressures stage 1; stage 1 holds when both stages are occupied.
  - out_valid is never retracted before acceptance.
- Latency: an accepted input appears at the outputs 2 cycles later, absent stalls.
- Simultaneous out-accept and in-accept while full: both occur in the same cycle and the data advances one stage.
- Stage 1 (registered on input accept):
  - Extend x to xe[3*GROUP_CNT-1:0] (sign or zero per SIGNED) and append xe[-1] = 0.
  - For each group i, take bits b3..b0 = xe[3i+2], xe[3i+1], xe[3i], xe[3i-1].
  - digit = -4*b3 + 2*b2 + b1 + b0, range -4..4.
  - Register the encoded s/d/t/q/n.
  - Register the low half of 3y: y[WIDTH/2-1:0] + {y,0}[WIDTH/2-1:0], together with its carry.
  - Register the extended y.
- Encoding rules:
  - s = (|digit| == 1), d = (|digit| == 2), t = (|digit| == 3), q = (|digit| == 4).
  - n = (digit < 0). Bit pattern 1111 gives digit 0 with n = 0.
  - At most one of s/d/t/q is set per group.
- Stage 2:
  - Compute the high half of 3y using the stage-1 carry.
  - Register the concatenated tmy (WIDTH+2 bits, two's complement when SIGNED = 1).
  - Register my = y and forward s..n.
- Invariant: sum over i of digit_i * 8^i == x (signed or unsigned per SIGNED).
- No arithmetic overflow is possible: 3y always fits in WIDTH+2 bits.

Decomposition:
- Shared package mb_pkg holds:
  - the GROUP_CNT formula;
  - the localparam for the radix-8 group stride (3);
  - a 5-bit booth_sel struct/encoding (s, d, t, q, n).
- One sub-module, booth_r8_digit: pure-combinational 4-bit-window to s/d/t/q/n encoder, instantiated GROUP_CNT times.
- Pipeline control and the split 3y adder stay in the top level.

Test Plan:
- SIGNED=1: x=0x0007, y=0x1234, out_ready=1 -> 2 cycles later s=6'b000011, n=6'b000001, d=t=q=0, my=0x1234, tmy=18'h0369C.
- SIGNED=1: x=0xFFFF (-1), y=0x8000 -> s=6'b000001, n=6'b000001, others 0; tmy=18'h28000 (-98304).
- SIGNED=0: x=0xFFFF -> s=6'b000001, d=6'b100000, n=6'b000001; y=0xFFFF -> tmy=18'h2FFFD.
- Back-to-back stream of 8 inputs with out_ready=1 -> 8 consecutive out_valid cycles, in order, no bubbles. Then out_ready=0 for 5 cycles -> outputs frozen, in_ready drops after 2 further accepts, and no data is lost or duplicated on resume.
- RST pulled low while 2 transactions are in flight -> out_valid=0 and outputs 0 immediately (asynchronous). After release, the first output corresponds to the first post-reset input.
- Random 10k x/y in both SIGNED modes, checked every cycle:
  - reconstructed sum over i of digit_i*8^i == x;
  - tmy == 3*y;
  - at most one of s/d/t/q set per group;
  - n=1 only when a magnitude bit is set.

Source files
------------

// File: rtl/mb_pkg.sv
// Shared definitions for the radix-8 Booth recoding pipeline.
package mb_pkg;

  localparam int GROUP_STRIDE = 3;

  typedef struct packed {
    logic s;
    logic d;
    logic t;
    logic q;
    logic n;
  } booth_sel_t;

  // Groups needed to cover a width-bit operand, including its sign extension.
  function automatic int group_cnt(input int width);
    return (width >> 2) + 2;
  endfunction

endpackage

// File: rtl/booth_r8_digit.sv
// Encodes one 4-bit radix-8 Booth window {b3,b2,b1,b0} into magnitude one-hots and a negate flag.
module booth_r8_digit
  import mb_pkg::*;
(
  input  logic [3:0] i_win,
  output booth_sel_t o_sel
);

  logic [3:0] w_digit;
  logic [3:0] w_abs;
  logic       w_neg;

  // -4*b3 + 2*b2 + b1 + b0 in 4-bit two's complement; 1111 wraps cleanly to zero.
  assign w_digit = {i_win[3], i_win[3], i_win[2], 1'b0}
                 + {3'b000, i_win[1]}
                 + {3'b000, i_win[0]};
  assign w_neg   = w_digit[3];
  assign w_abs   = w_neg ? (4'd0 - w_digit) : w_digit;

  assign o_sel.s = (w_abs == 4'd1);
  assign o_sel.d = (w_abs == 4'd2);
  assign o_sel.t = (w_abs == 4'd3);
  assign o_sel.q = (w_abs == 4'd4);
  assign o_sel.n = w_neg;

endmodule

// File: rtl/mb16_booth_enc.sv
// Radix-8 Booth recoder: two-stage valid/ready pipeline producing per-group
// digit selects, the registered multiplicand and the hard multiple 3*y.
module mb16_booth_enc
  import mb_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int SIGNED    = 1,
  localparam int GROUP_CNT = group_cnt(WIDTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [GROUP_CNT-1:0] s,
  output logic [GROUP_CNT-1:0] d,
  output logic [GROUP_CNT-1:0] t,
  output logic [GROUP_CNT-1:0] q,
  output logic [GROUP_CNT-1:0] n,
  output logic [WIDTH-1:0]     my,
  output logic [WIDTH+1:0]     tmy
);

  localparam int XE_W = GROUP_STRIDE * GROUP_CNT;
  localparam int TW   = WIDTH + 2;
  localparam int HALF = WIDTH / 2;
  localparam int HI_W = TW - HALF;

  logic r_v1, r_v2;
  logic w_take_in, w_adv;

  // Stage 2 frees up when empty or drained this cycle; stage 1 only blocks when both are full.
  assign in_ready  = ~r_v1 | ~r_v2 | out_ready;
  assign w_take_in = in_valid & in_ready;
  assign w_adv     = r_v1 & (~r_v2 | out_ready);
  assign out_valid = r_v2;

  logic            w_x_ext, w_y_ext;
  logic [XE_W:0]   w_xwin;
  logic [TW-1:0]   w_ye;
  logic [HALF:0]   w_lo;

  assign w_x_ext = (SIGNED != 0) & x[WIDTH-1];
  assign w_y_ext = (SIGNED != 0) & y[WIDTH-1];
  assign w_xwin  = {{(XE_W - WIDTH){w_x_ext}}, x, 1'b0};
  assign w_ye    = {{2{w_y_ext}}, y};
  assign w_lo    = {1'b0, y[HALF-1:0]} + {1'b0, y[HALF-2:0], 1'b0};

  logic [GROUP_CNT-1:0] w_s, w_d, w_t, w_q, w_n;

  for (genvar g = 0; g < GROUP_CNT; g++) begin : g_digit
    booth_sel_t w_sel;
    booth_r8_digit u_digit (
      .i_win (w_xwin[GROUP_STRIDE*g +: 4]),
      .o_sel (w_sel)
    );
    assign w_s[g] = w_sel.s;
    assign w_d[g] = w_sel.d;
    assign w_t[g] = w_sel.t;
    assign w_q[g] = w_sel.q;
    assign w_n[g] = w_sel.n;
  end

  logic [GROUP_CNT-1:0] r_s1, r_d1, r_t1, r_q1, r_n1;
  logic [TW-1:0]        r_ye1;
  logic [HALF-1:0]      r_lo1;
  logic                 r_c1;

  // NOTE: data registers are reset as well as the valid bits, so every output reads zero during reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_v1  <= 1'b0;
      r_s1  <= '0;
      r_d1  <= '0;
      r_t1  <= '0;
      r_q1  <= '0;
      r_n1  <= '0;
      r_ye1 <= '0;
      r_lo1 <= '0;
      r_c1  <= 1'b0;
    end else begin
      if (w_take_in)  r_v1 <= 1'b1;
      else if (w_adv) r_v1 <= 1'b0;
      if (w_take_in) begin
        r_s1  <= w_s;
        r_d1  <= w_d;
        r_t1  <= w_t;
        r_q1  <= w_q;
        r_n1  <= w_n;
        r_ye1 <= w_ye;
        r_lo1 <= w_lo[HALF-1:0];
        r_c1  <= w_lo[HALF];
      end
    end
  end

  // Upper half of ye + 2*ye; bit HALF-1 of ye lands at bit HALF of 2*ye.
  logic [HI_W-1:0] w_hi;
  assign w_hi = r_ye1[TW-1:HALF] + r_ye1[TW-2:HALF-1] + HI_W'(r_c1);

  logic [GROUP_CNT-1:0] r_s2, r_d2, r_t2, r_q2, r_n2;
  logic [WIDTH-1:0]     r_my2;
  logic [TW-1:0]        r_tmy2;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_v2   <= 1'b0;
      r_s2   <= '0;
      r_d2   <= '0;
      r_t2   <= '0;
      r_q2   <= '0;
      r_n2   <= '0;
      r_my2  <= '0;
      r_tmy2 <= '0;
    end else begin
      if (w_adv)          r_v2 <= 1'b1;
      else if (out_ready) r_v2 <= 1'b0;
      if (w_adv) begin
        r_s2   <= r_s1;
        r_d2   <= r_d1;
        r_t2   <= r_t1;
        r_q2   <= r_q1;
        r_n2   <= r_n1;
        r_my2  <= r_ye1[WIDTH-1:0];
        r_tmy2 <= {w_hi, r_lo1};
      end
    end
  end

  assign s   = r_s2;
  assign d   = r_d2;
  assign t   = r_t2;
  assign q   = r_q2;
  assign n   = r_n2;
  assign my  = r_my2;
  assign tmy = r_tmy2;

endmodule

// File: tb/tb_mb16_booth_enc.sv
// Bench for mb16_booth_enc: a signed and an unsigned instance share one stimulus stream.
module tb_mb16_booth_enc;

  logic        CLK, RST;
  logic        in_valid, out_ready;
  logic [15:0] x, y;

  logic        ov_s, ir_s, ov_u, ir_u;
  logic [5:0]  s_s, d_s, t_s, q_s, n_s, s_u, d_u, t_u, q_u, n_u;
  logic [15:0] my_s, my_u;
  logic [17:0] tmy_s, tmy_u;

  mb16_booth_enc #(.WIDTH(16), .SIGNED(1)) u_dut_s (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(ir_s), .x(x), .y(y),
    .out_valid(ov_s), .out_ready(out_ready), .s(s_s), .d(d_s), .t(t_s), .q(q_s),
    .n(n_s), .my(my_s), .tmy(tmy_s)
  );

  mb16_booth_enc #(.WIDTH(16), .SIGNED(0)) u_dut_u (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(ir_u), .x(x), .y(y),
    .out_valid(ov_u), .out_ready(out_ready), .s(s_u), .d(d_u), .t(t_u), .q(q_u),
    .n(n_u), .my(my_u), .tmy(tmy_u)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct packed {
    logic        ov;
    logic        ir;
    logic [5:0]  s, d, t, q, n;
    logic [15:0] my;
    logic [17:0] tmy;
  } obs_t;

  typedef struct packed {
    logic [15:0] x;
    logic [5:0]  s, d, t, q, n;
    logic [15:0] my;
    logic [17:0] tmy;
  } exp_t;

  typedef struct {
    bit          sgn;
    logic [15:0] x, y;
    logic [5:0]  s, d, t, q, n;
    logic [17:0] tmy;
  } vec_t;

  obs_t obs_s, obs_u;
  assign obs_s = {ov_s, ir_s, s_s, d_s, t_s, q_s, n_s, my_s, tmy_s};
  assign obs_u = {ov_u, ir_u, s_u, d_u, t_u, q_u, n_u, my_u, tmy_u};

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q_s[$];
  exp_t exp_q_u[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic obs_t get_obs(input bit sgn);
    return sgn ? obs_s : obs_u;
  endfunction

  // Bit k of x extended to 18 bits, with bit -1 reading as zero.
  function automatic int xbit(input bit sgn, input logic [15:0] xv, input int k);
    if (k < 0)  return 0;
    if (k > 15) return sgn ? int'(xv[15]) : 0;
    return int'(xv[k]);
  endfunction

  function automatic exp_t model(input bit sgn, input logic [15:0] xv, input logic [15:0] yv);
    exp_t   e;
    longint yi;
    int     dg, mag;
    e    = '0;
    e.x  = xv;
    e.my = yv;
    yi   = sgn ? longint'($signed(yv)) : longint'(yv);
    e.tmy = 18'(yi * 3);
    for (int i = 0; i < 6; i++) begin
      dg  = -4 * xbit(sgn, xv, 3*i+2) + 2 * xbit(sgn, xv, 3*i+1)
            + xbit(sgn, xv, 3*i) + xbit(sgn, xv, 3*i-1);
      mag = (dg < 0) ? -dg : dg;
      e.s[i] = (mag == 1);
      e.d[i] = (mag == 2);
      e.t[i] = (mag == 3);
      e.q[i] = (mag == 4);
      e.n[i] = (dg < 0);
    end
    return e;
  endfunction

  task automatic compare(input bit sgn, input obs_t o, input exp_t e);
    string  p;
    longint acc, w, xi, yi, ti;
    int     bad, m;
    p = sgn ? "S" : "U";
    check({p, ".s"},   longint'(o.s),   longint'(e.s));
    check({p, ".d"},   longint'(o.d),   longint'(e.d));
    check({p, ".t"},   longint'(o.t),   longint'(e.t));
    check({p, ".q"},   longint'(o.q),   longint'(e.q));
    check({p, ".n"},   longint'(o.n),   longint'(e.n));
    check({p, ".my"},  longint'(o.my),  longint'(e.my));
    check({p, ".tmy"}, longint'(o.tmy), longint'(e.tmy));
    acc = 0;
    w   = 1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      m = o.s[i] ? 1 : o.d[i] ? 2 : o.t[i] ? 3 : o.q[i] ? 4 : 0;
      if ($countones({o.s[i], o.d[i], o.t[i], o.q[i]}) > 1) bad++;
      if (o.n[i] && m == 0) bad++;
      acc += longint'(o.n[i] ? -m : m) * w;
      w   *= 8;
    end
    xi = sgn ? longint'($signed(e.x))   : longint'(e.x);
    yi = sgn ? longint'($signed(e.my))  : longint'(e.my);
    ti = sgn ? longint'($signed(o.tmy)) : longint'(o.tmy);
    check({p, ".recon"},    acc, xi);
    check({p, ".onehot_n"}, longint'(bad), 0);
    check({p, ".tmy_3y"},   ti, 3 * yi);
  endtask

  // Scoreboard: samples mid-cycle, where handshake signals hold their values for the next edge.
  task automatic monitor();
    obs_t o;
    exp_t e;
    bit   sg;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        exp_q_s.delete();
        exp_q_u.delete();
      end else begin
        for (int k = 0; k < 2; k++) begin
          sg = (k == 1);
          o  = get_obs(sg);
          if (o.ov && out_ready) begin
            if ((sg ? exp_q_s.size() : exp_q_u.size()) == 0) begin
              check(sg ? "S.unexpected_out" : "U.unexpected_out", 1, 0);
            end else begin
              e = sg ? exp_q_s.pop_front() : exp_q_u.pop_front();
              compare(sg, o, e);
            end
          end
          if (in_valid && o.ir) begin
            if (sg) exp_q_s.push_back(model(1'b1, x, y));
            else    exp_q_u.push_back(model(1'b0, x, y));
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom % 8)
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  vec_t        tbl[6];
  obs_t        o;
  exp_t        ea, ep;
  logic [15:0] xa, ya, xp, yp;

  initial begin
    tbl[0] = '{1'b1, 16'h0007, 16'h1234, 6'b000011, 6'b0, 6'b0, 6'b0, 6'b000001, 18'h0369C};
    tbl[1] = '{1'b1, 16'hFFFF, 16'h8000, 6'b000001, 6'b0, 6'b0, 6'b0, 6'b000001, 18'h28000};
    tbl[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 6'b000001, 6'b100000, 6'b0, 6'b0, 6'b000001, 18'h2FFFD};
    tbl[3] = '{1'b1, 16'h8000, 16'h7FFF, 6'b100000, 6'b0, 6'b0, 6'b0, 6'b100000, 18'h17FFD};
    tbl[4] = '{1'b1, 16'h0004, 16'h7FFF, 6'b000010, 6'b0, 6'b0, 6'b000001, 6'b000001, 18'h17FFD};
    tbl[5] = '{1'b0, 16'h0003, 16'h8000, 6'b0, 6'b0, 6'b000001, 6'b0, 6'b0, 18'h18000};

    RST       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
    fork
      monitor();
    join_none

    // Reset state
    tick();
    tick();
    check("rst.ov_s", longint'(ov_s), 0);
    check("rst.ov_u", longint'(ov_u), 0);
    check("rst.data_s", longint'({s_s, d_s, t_s, q_s, n_s}), 0);
    check("rst.tmy_s", longint'(tmy_s), 0);
    check("rst.my_u", longint'(my_u), 0);
    RST = 1'b1;
    #1;
    check("rst.ir_s", longint'(ir_s), 1);
    check("rst.ir_u", longint'(ir_u), 1);

    // Directed vectors with exact two-cycle latency
    for (int i = 0; i < 6; i++) begin
      x = tbl[i].x;
      y = tbl[i].y;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      o = get_obs(tbl[i].sgn);
      check("vec.lat1_valid", longint'(o.ov), 0);
      tick();
      o = get_obs(tbl[i].sgn);
      check("vec.lat2_valid", longint'(o.ov), 1);
      check("vec.s",   longint'(o.s),   longint'(tbl[i].s));
      check("vec.d",   longint'(o.d),   longint'(tbl[i].d));
      check("vec.t",   longint'(o.t),   longint'(tbl[i].t));
      check("vec.q",   longint'(o.q),   longint'(tbl[i].q));
      check("vec.n",   longint'(o.n),   longint'(tbl[i].n));
      check("vec.my",  longint'(o.my),  longint'(tbl[i].y));
      check("vec.tmy", longint'(o.tmy), longint'(tbl[i].tmy));
      tick();
    end

    // Back-to-back stream: eight consecutive outputs with no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        in_valid = 1'b1;
        x = pick();
        y = pick();
        check("stream.ir", longint'(ir_s), 1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check("stream.ov", longint'(ov_s), (i >= 1 && i <= 8) ? 1 : 0);
    end

    // Stall: two more accepts, then in_ready drops and outputs hold the first one
    xa = pick();
    ya = pick();
    ea = model(1'b1, xa, ya);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x = xa;
    y = ya;
    for (int k = 0; k < 5; k++) begin
      check("stall.ir", longint'(ir_s), (k < 2) ? 1 : 0);
      tick();
      if (k == 0) begin
        x = 16'h1357;
        y = 16'h2468;
        check("stall.ov0", longint'(ov_s), 0);
      end else begin
        if (k == 1) begin
          x = 16'hFEDC;
          y = 16'h0BA9;
        end
        check("stall.ov",  longint'(ov_s), 1);
        check("stall.sel", longint'({s_s, d_s, t_s, q_s, n_s}),
              longint'({ea.s, ea.d, ea.t, ea.q, ea.n}));
        check("stall.my",  longint'(my_s),  longint'(ea.my));
        check("stall.tmy", longint'(tmy_s), longint'(ea.tmy));
      end
    end
    out_ready = 1'b1;
    #1;
    check("resume.ir", longint'(ir_s), 1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("resume.drained_ov", longint'(ov_s), 0);
    check("resume.q_s_empty", longint'(exp_q_s.size()), 0);
    check("resume.q_u_empty", longint'(exp_q_u.size()), 0);

    // Asynchronous reset with two transactions in flight
    in_valid = 1'b1;
    x = 16'h4321;
    y = 16'h0F0F;
    tick();
    x = 16'h8765;
    y = 16'hF0F0;
    tick();
    in_valid = 1'b0;
    check("prerst.ov", longint'(ov_s), 1);
    #1;
    RST = 1'b0;
    #1;
    check("midrst.ov_s", longint'(ov_s), 0);
    check("midrst.ov_u", longint'(ov_u), 0);
    check("midrst.sel_s", longint'({s_s, d_s, t_s, q_s, n_s}), 0);
    check("midrst.my_s", longint'(my_s), 0);
    check("midrst.tmy_u", longint'(tmy_u), 0);
    tick();
    tick();
    #1;
    RST = 1'b1;
    xp = 16'h0ACE;
    yp = 16'hC0DE;
    ep = model(1'b1, xp, yp);
    x = xp;
    y = yp;
    in_valid = 1'b1;
    check("postrst.ir", longint'(ir_s), 1);
    tick();
    in_valid = 1'b0;
    check("postrst.ov1", longint'(ov_s), 0);
    tick();
    check("postrst.ov2", longint'(ov_s), 1);
    check("postrst.my",  longint'(my_s),  longint'(yp));
    check("postrst.sel", longint'({s_s, d_s, t_s, q_s, n_s}),
          longint'({ep.s, ep.d, ep.t, ep.q, ep.n}));
    tick();

    // Random traffic on both instances, checked by the scoreboard
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      x = pick();
      y = pick();
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    check("final.q_s_empty", longint'(exp_q_s.size()), 0);
    check("final.q_u_empty", longint'(exp_q_u.size()), 0);
    check("final.ov_s", longint'(ov_s), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
